// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA timing source, colour realignment, blanking and pin drive.
// Define VGA_SYNC_BORDER_EN to force a white frame around the visible area.
module vga_sync_gen #(
    parameter int c_TOTAL_COLS    = 800,
    parameter int c_TOTAL_ROWS    = 525,
    parameter int c_ACTIVE_COLS   = 640,
    parameter int c_ACTIVE_ROWS   = 480,
    parameter int c_H_FRONT_PORCH = 16,
    parameter int c_H_SYNC_WIDTH  = 96,
    parameter int c_V_FRONT_PORCH = 10,
    parameter int c_V_SYNC_WIDTH  = 2,
    parameter int c_VIDEO_DELAY   = 2
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    output logic       o_HSync,
    output logic       o_VSync,
    output logic [9:0] o_Col_Count,
    output logic [9:0] o_Row_Count,
    output logic       o_Frame_Start,
    input  logic [3:0] i_Red_Video,
    input  logic [3:0] i_Grn_Video,
    input  logic [3:0] i_Blu_Video,
    output logic       o_VGA_HSync,
    output logic       o_VGA_VSync,
    output logic [3:0] o_VGA_Red,
    output logic [3:0] o_VGA_Grn,
    output logic [3:0] o_VGA_Blu
);

    localparam int D = c_VIDEO_DELAY;

    localparam logic [9:0] H_LAST    = 10'(c_TOTAL_COLS - 1);
    localparam logic [9:0] H_FRONT_S = 10'(c_ACTIVE_COLS);
    localparam logic [9:0] H_SYNC_S  = 10'(c_ACTIVE_COLS + c_H_FRONT_PORCH);
    localparam logic [9:0] H_BACK_S  =
        10'(c_ACTIVE_COLS + c_H_FRONT_PORCH + c_H_SYNC_WIDTH);

    localparam logic [9:0] V_LAST    = 10'(c_TOTAL_ROWS - 1);
    localparam logic [9:0] V_FRONT_S = 10'(c_ACTIVE_ROWS);
    localparam logic [9:0] V_SYNC_S  = 10'(c_ACTIVE_ROWS + c_V_FRONT_PORCH);
    localparam logic [9:0] V_BACK_S  =
        10'(c_ACTIVE_ROWS + c_V_FRONT_PORCH + c_V_SYNC_WIDTH);

`ifndef SYNTHESIS
    if (c_ACTIVE_COLS + c_H_FRONT_PORCH + c_H_SYNC_WIDTH >= c_TOTAL_COLS)
    begin : g_h_chk
        $error("vga_sync_gen: horizontal timing does not fit the line");
    end
    if (c_ACTIVE_ROWS + c_V_FRONT_PORCH + c_V_SYNC_WIDTH >= c_TOTAL_ROWS)
    begin : g_v_chk
        $error("vga_sync_gen: vertical timing does not fit the frame");
    end
    if (c_VIDEO_DELAY < 1 || c_VIDEO_DELAY > 7) begin : g_d_chk
        $error("vga_sync_gen: c_VIDEO_DELAY must be 1..7");
    end
    if (c_TOTAL_COLS > 1024 || c_TOTAL_ROWS > 1024) begin : g_w_chk
        $error("vga_sync_gen: counters are 10 bits wide");
    end
    if (c_ACTIVE_COLS < 1 || c_ACTIVE_ROWS < 1 || c_H_FRONT_PORCH < 1 ||
        c_H_SYNC_WIDTH < 1 || c_V_FRONT_PORCH < 1 || c_V_SYNC_WIDTH < 1)
    begin : g_z_chk
        $error("vga_sync_gen: every timing region must be non-empty");
    end
`endif

    typedef enum logic [1:0] {H_ACTIVE, H_FRONT, H_SYNC, H_BACK} h_state_t;
    typedef enum logic [1:0] {V_ACTIVE, V_FRONT, V_SYNC, V_BACK} v_state_t;

    logic [9:0] col;
    logic [9:0] row;
    logic [9:0] col_nxt;
    logic [9:0] row_nxt;
    logic       col_wrap;
    h_state_t   h_state;
    v_state_t   v_state;

    always_comb begin
        col_wrap = (col == H_LAST);
        col_nxt  = col_wrap ? 10'd0 : col + 10'd1;
        row_nxt  = row;
        if (col_wrap) begin
            row_nxt = (row == V_LAST) ? 10'd0 : row + 10'd1;
        end
    end

    // Region FSMs move on the counter value being loaded, so they stay in step.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            col     <= '0;
            row     <= '0;
            h_state <= H_ACTIVE;
            v_state <= V_ACTIVE;
        end else begin
            col <= col_nxt;
            row <= row_nxt;
            unique case (h_state)
                H_ACTIVE: if (col_nxt == H_FRONT_S) h_state <= H_FRONT;
                H_FRONT:  if (col_nxt == H_SYNC_S)  h_state <= H_SYNC;
                H_SYNC:   if (col_nxt == H_BACK_S)  h_state <= H_BACK;
                H_BACK:   if (col_nxt == 10'd0)     h_state <= H_ACTIVE;
                default:  h_state <= H_ACTIVE;
            endcase
            if (col_wrap) begin
                unique case (v_state)
                    V_ACTIVE: if (row_nxt == V_FRONT_S) v_state <= V_FRONT;
                    V_FRONT:  if (row_nxt == V_SYNC_S)  v_state <= V_SYNC;
                    V_SYNC:   if (row_nxt == V_BACK_S)  v_state <= V_BACK;
                    V_BACK:   if (row_nxt == 10'd0)     v_state <= V_ACTIVE;
                    default:  v_state <= V_ACTIVE;
                endcase
            end
        end
    end

    logic act_q;
    logic hs_q;
    logic vs_q;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            o_HSync       <= 1'b0;
            o_VSync       <= 1'b0;
            o_Col_Count   <= '0;
            o_Row_Count   <= '0;
            o_Frame_Start <= 1'b0;
            act_q         <= 1'b0;
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
        end else begin
            o_HSync       <= (h_state == H_ACTIVE);
            o_VSync       <= (v_state == V_ACTIVE);
            o_Col_Count   <= col;
            o_Row_Count   <= row;
            o_Frame_Start <= (col == 10'd0) && (row == 10'd0);
            act_q         <= (h_state == H_ACTIVE) && (v_state == V_ACTIVE);
            hs_q          <= (h_state == H_SYNC);
            vs_q          <= (v_state == V_SYNC);
        end
    end

    logic [D-1:0] act_pipe;
    logic [D-1:0] hs_pipe;
    logic [D-1:0] vs_pipe;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            act_pipe <= '0;
            hs_pipe  <= '0;
            vs_pipe  <= '0;
        end else begin
            act_pipe[0] <= act_q;
            hs_pipe[0]  <= hs_q;
            vs_pipe[0]  <= vs_q;
            for (int i = 1; i < D; i++) begin
                act_pipe[i] <= act_pipe[i-1];
                hs_pipe[i]  <= hs_pipe[i-1];
                vs_pipe[i]  <= vs_pipe[i-1];
            end
        end
    end

`ifdef VGA_SYNC_BORDER_EN
    localparam logic [9:0] H_ACT_LAST = 10'(c_ACTIVE_COLS - 1);
    localparam logic [9:0] V_ACT_LAST = 10'(c_ACTIVE_ROWS - 1);

    logic [9:0] col_pipe [D];
    logic [9:0] row_pipe [D];
    logic       on_border;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            for (int i = 0; i < D; i++) begin
                col_pipe[i] <= '0;
                row_pipe[i] <= '0;
            end
        end else begin
            col_pipe[0] <= o_Col_Count;
            row_pipe[0] <= o_Row_Count;
            for (int i = 1; i < D; i++) begin
                col_pipe[i] <= col_pipe[i-1];
                row_pipe[i] <= row_pipe[i-1];
            end
        end
    end

    always_comb begin
        on_border = (col_pipe[D-1] == 10'd0) || (col_pipe[D-1] == H_ACT_LAST) ||
                    (row_pipe[D-1] == 10'd0) || (row_pipe[D-1] == V_ACT_LAST);
    end
`endif

    logic [3:0] red_nxt;
    logic [3:0] grn_nxt;
    logic [3:0] blu_nxt;

    always_comb begin
        red_nxt = '0;
        grn_nxt = '0;
        blu_nxt = '0;
        if (act_pipe[D-1]) begin
            red_nxt = i_Red_Video;
            grn_nxt = i_Grn_Video;
            blu_nxt = i_Blu_Video;
`ifdef VGA_SYNC_BORDER_EN
            if (on_border) begin
                red_nxt = 4'hF;
                grn_nxt = 4'hF;
                blu_nxt = 4'hF;
            end
`endif
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            o_VGA_HSync <= 1'b1;
            o_VGA_VSync <= 1'b1;
            o_VGA_Red   <= '0;
            o_VGA_Grn   <= '0;
            o_VGA_Blu   <= '0;
        end else begin
            o_VGA_HSync <= ~hs_pipe[D-1];
            o_VGA_VSync <= ~vs_pipe[D-1];
            o_VGA_Red   <= red_nxt;
            o_VGA_Grn   <= grn_nxt;
            o_VGA_Blu   <= blu_nxt;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: random-colour bench for a shrunk and a default-timing
// vga_sync_gen, checked every clock against an arithmetic timing model.
module tb_vga_sync_gen;

    localparam int D = 2;

    localparam int S_TC  = 40;
    localparam int S_TR  = 20;
    localparam int S_AC  = 24;
    localparam int S_AR  = 12;
    localparam int S_HFP = 4;
    localparam int S_HSW = 6;
    localparam int S_VFP = 2;
    localparam int S_VSW = 2;

    typedef struct packed {
        logic [9:0] col;
        logic [9:0] row;
        logic       hs;
        logic       vs;
        logic       fs;
        logic       phs;
        logic       pvs;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] vr;
    logic [3:0] vg;
    logic [3:0] vb;

    logic       s_hs, s_vs, s_fs, s_phs, s_pvs;
    logic [9:0] s_col, s_row;
    logic [3:0] s_r, s_g, s_b;
    logic       d_hs, d_vs, d_fs, d_phs, d_pvs;
    logic [9:0] d_col, d_row;
    logic [3:0] d_r, d_g, d_b;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    vga_sync_gen #(
        .c_TOTAL_COLS   (S_TC),
        .c_TOTAL_ROWS   (S_TR),
        .c_ACTIVE_COLS  (S_AC),
        .c_ACTIVE_ROWS  (S_AR),
        .c_H_FRONT_PORCH(S_HFP),
        .c_H_SYNC_WIDTH (S_HSW),
        .c_V_FRONT_PORCH(S_VFP),
        .c_V_SYNC_WIDTH (S_VSW),
        .c_VIDEO_DELAY  (D)
    ) u_small (
        .i_Clk        (clk),
        .i_Rst_L      (rst_n),
        .o_HSync      (s_hs),
        .o_VSync      (s_vs),
        .o_Col_Count  (s_col),
        .o_Row_Count  (s_row),
        .o_Frame_Start(s_fs),
        .i_Red_Video  (vr),
        .i_Grn_Video  (vg),
        .i_Blu_Video  (vb),
        .o_VGA_HSync  (s_phs),
        .o_VGA_VSync  (s_pvs),
        .o_VGA_Red    (s_r),
        .o_VGA_Grn    (s_g),
        .o_VGA_Blu    (s_b)
    );

    vga_sync_gen u_dflt (
        .i_Clk        (clk),
        .i_Rst_L      (rst_n),
        .o_HSync      (d_hs),
        .o_VSync      (d_vs),
        .o_Col_Count  (d_col),
        .o_Row_Count  (d_row),
        .o_Frame_Start(d_fs),
        .i_Red_Video  (vr),
        .i_Grn_Video  (vg),
        .i_Blu_Video  (vb),
        .o_VGA_HSync  (d_phs),
        .o_VGA_VSync  (d_pvs),
        .o_VGA_Red    (d_r),
        .o_VGA_Grn    (d_g),
        .o_VGA_Blu    (d_b)
    );

    // k counts clocks since reset release; pins show the pixel of k-D-1.
    function automatic exp_t model(input int k, input int tc, input int tr,
                                   input int ac, input int ar,
                                   input int hfp, input int hsw,
                                   input int vfp, input int vsw,
                                   input logic [3:0] cr, input logic [3:0] cg,
                                   input logic [3:0] cb);
        exp_t e;
        int   c;
        int   r;
        int   j;
        c     = k % tc;
        r     = (k / tc) % tr;
        e.col = 10'(c);
        e.row = 10'(r);
        e.hs  = (c < ac);
        e.vs  = (r < ar);
        e.fs  = (c == 0) && (r == 0);
        e.phs = 1'b1;
        e.pvs = 1'b1;
        e.r   = 4'h0;
        e.g   = 4'h0;
        e.b   = 4'h0;
        j     = k - D - 1;
        if (j >= 0) begin
            c     = j % tc;
            r     = (j / tc) % tr;
            e.phs = !(c >= ac + hfp && c < ac + hfp + hsw);
            e.pvs = !(r >= ar + vfp && r < ar + vfp + vsw);
            if (c < ac && r < ar) begin
                e.r = cr;
                e.g = cg;
                e.b = cb;
`ifdef VGA_SYNC_BORDER_EN
                if (c == 0 || c == ac - 1 || r == 0 || r == ar - 1) begin
                    e.r = 4'hF;
                    e.g = 4'hF;
                    e.b = 4'hF;
                end
`endif
            end
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [9:0] obs,
                       input logic [9:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d (t=%0t)",
                    tag, obs, exp, $time);
    endtask

    task automatic chk_all(input string p, input exp_t e,
                           input logic [9:0] col, input logic [9:0] row,
                           input logic hs, input logic vs, input logic fs,
                           input logic phs, input logic pvs,
                           input logic [3:0] r, input logic [3:0] g,
                           input logic [3:0] b);
        chk({p, "col"}, col, e.col);
        chk({p, "row"}, row, e.row);
        chk({p, "hsync"}, 10'(hs), 10'(e.hs));
        chk({p, "vsync"}, 10'(vs), 10'(e.vs));
        chk({p, "frame_start"}, 10'(fs), 10'(e.fs));
        chk({p, "pin_hsync"}, 10'(phs), 10'(e.phs));
        chk({p, "pin_vsync"}, 10'(pvs), 10'(e.pvs));
        chk({p, "red"}, 10'(r), 10'(e.r));
        chk({p, "grn"}, 10'(g), 10'(e.g));
        chk({p, "blu"}, 10'(b), 10'(e.b));
    endtask

    // k < 0 means the edge is a reset edge.
    task automatic cycle(input int k, input logic rst_val);
        exp_t es;
        exp_t ed;
        @(negedge clk);
        rst_n = rst_val;
        vr    = 4'($urandom_range(0, 15));
        vg    = 4'($urandom_range(0, 15));
        vb    = 4'($urandom_range(0, 15));
        @(posedge clk);
        #1;
        if (k < 0) begin
            es = '{col: 10'd0, row: 10'd0, hs: 1'b0, vs: 1'b0, fs: 1'b0,
                   phs: 1'b1, pvs: 1'b1, r: 4'h0, g: 4'h0, b: 4'h0};
            ed = es;
        end else begin
            es = model(k, S_TC, S_TR, S_AC, S_AR, S_HFP, S_HSW, S_VFP, S_VSW,
                       vr, vg, vb);
            ed = model(k, 800, 525, 640, 480, 16, 96, 10, 2, vr, vg, vb);
        end
        chk_all("small_", es, s_col, s_row, s_hs, s_vs, s_fs,
                s_phs, s_pvs, s_r, s_g, s_b);
        chk_all("dflt_", ed, d_col, d_row, d_hs, d_vs, d_fs,
                d_phs, d_pvs, d_r, d_g, d_b);
    endtask

    initial begin
        rst_n = 1'b0;
        vr    = 4'h0;
        vg    = 4'h0;
        vb    = 4'h0;
        for (int i = 0; i < 5; i++) cycle(-1, 1'b0);
        // Three small frames plus a few lines, then stop in small H_SYNC.
        for (int k = 0; k <= 2630; k++) cycle(k, 1'b1);
        chk("small_in_hsync_col", s_col, 10'd30);
        for (int i = 0; i < 3; i++) cycle(-1, 1'b0);
        for (int k = 0; k < 1700; k++) cycle(k, 1'b1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Transmit-side VGA timing source for the raccoon game. It produces the active-window HSync/VSync pair that the game's sync-to-count logic consumes. It also takes back the game's registered colour output, realigns it, blanks it outside the visible area, and drives the physical VGA pins with correctly placed active-low sync pulses. It sits between the top-level clock/reset and both the game core and the VGA connector.

## Interface
- c_TOTAL_COLS, 800, columns per line including blanking
- c_TOTAL_ROWS, 525, rows per frame including blanking
- c_ACTIVE_COLS, 640, visible columns
- c_ACTIVE_ROWS, 480, visible rows
- c_H_FRONT_PORCH, 16, columns between end of active and start of HSync pulse
- c_H_SYNC_WIDTH, 96, HSync pulse width in columns
- c_V_FRONT_PORCH, 10, rows between end of active and start of VSync pulse
- c_V_SYNC_WIDTH, 2, VSync pulse width in rows
- c_VIDEO_DELAY, 2, clocks from o_HSync/o_VSync to matching i_*_Video (range 1..7)

Ports:
- i_Clk  in  1  pixel clock (25 MHz nominal)
- i_Rst_L  in  1  reset, synchronous, active-low
- o_HSync  out  1  high while column < c_ACTIVE_COLS (to game)
- o_VSync  out  1  high while row < c_ACTIVE_ROWS (to game)
- o_Col_Count  out  10  current column, 0..c_TOTAL_COLS-1
- o_Row_Count  out  10  current row, 0..c_TOTAL_ROWS-1
- o_Frame_Start  out  1  one-clock pulse when col=0,row=0
- i_Red_Video / i_Grn_Video / i_Blu_Video  in  4 each  game colour, c_VIDEO_DELAY clocks behind o_HSync/o_VSync
- o_VGA_HSync  out  1  physical HSync, active-low
- o_VGA_VSync  out  1  physical VSync, active-low
- o_VGA_Red / o_VGA_Grn / o_VGA_Blu  out  4 each  blanked colour to pins

## Operation
- Column counter increments every clock; at c_TOTAL_COLS-1 wraps to 0 and advances row counter; row wraps at c_TOTAL_ROWS-1 to 0.
- Horizontal FSM states H_ACTIVE, H_FRONT, H_SYNC, H_BACK, decoded from column:
  - [0, A) is H_ACTIVE, with A = c_ACTIVE_COLS.
  - [A, A+FP) is H_FRONT.
  - [A+FP, A+FP+SW) is H_SYNC.
  - The remainder of the line is H_BACK.
- Vertical FSM V_ACTIVE, V_FRONT, V_SYNC, V_BACK, identical scheme on rows. Vertical state advances only on column wrap.
- o_HSync/o_VSync/o_Col_Count/o_Row_Count/o_Frame_Start all registered from the same counter state (mutually aligned).
- Alignment pipeline: active flag (H_ACTIVE && V_ACTIVE), H_SYNC flag and V_SYNC flag are shifted through c_VIDEO_DELAY stages so they coincide with incoming i_*_Video.
- Output stage (one further register):
  - Delayed active = 1: o_VGA_* = i_*_Video.
  - Delayed active = 0: o_VGA_* = 0.
  - o_VGA_HSync = ~delayed H_SYNC; o_VGA_VSync = ~delayed V_SYNC.
- Parameters must satisfy ACTIVE+FP+SW < TOTAL on each axis. This is checked by an elaboration-time $error guarded for simulation.

## Timing
- Reset (i_Rst_L=0 at a clock edge):
  - Counters = 0, FSMs = H_ACTIVE/V_ACTIVE, all pipeline stages cleared.
  - o_HSync = 0, o_VSync = 0, o_Col_Count = 0, o_Row_Count = 0, o_Frame_Start = 0.
  - o_VGA_HSync = 1, o_VGA_VSync = 1, o_VGA_* colour = 0.
- First clock after release: o_Col_Count=0, o_Row_Count=0, o_HSync=1, o_VSync=1, o_Frame_Start=1.
- Reset asserted mid-frame: takes effect at the next edge regardless of state; no partial sync pulse is extended. Pin syncs return high immediately.
- Pin outputs lag o_HSync/o_VSync by c_VIDEO_DELAY+1 clocks. Colour of column N appears on pins c_VIDEO_DELAY+1 clocks after o_Col_Count=N.
- Default parameters:
  - HSync low for 96 clocks per line, starting 656 clocks after the line's first active pixel.
  - VSync low for 2 lines starting at row 490.
- Line wrap and frame wrap in the same clock: row resets to 0 and o_Frame_Start asserts the following clock.

## Configuration
- VGA_SYNC_BORDER_EN defined: any pixel in the delayed active window that lies on column 0, column c_ACTIVE_COLS-1, row 0 or row c_ACTIVE_ROWS-1 is forced to 4'b1111 on all three colours, overriding i_*_Video. Column/row are delayed alongside the active flag.
- Undefined: no override; the border logic and its delayed counters are absent.

## Test plan
- Reset release: i_Rst_L low for 5 clocks, then high -> pins idle (syncs 1, colour 0) during reset; first clock after release gives col=0, row=0, o_Frame_Start=1.
- Line timing: run 2 full lines -> o_HSync high exactly 640 clocks per 800; o_VGA_HSync low exactly 96 clocks, falling edge 656+c_VIDEO_DELAY+1 clocks after the o_HSync rise.
- Frame timing: run 2 frames -> o_VSync high 480 lines per 525; o_VGA_VSync low for 2 lines (1600 clocks) starting row 490; o_Frame_Start period 420000 clocks.
- Blanking/alignment: i_*_Video held at 4'hA with c_VIDEO_DELAY=2 -> o_VGA_* equals 4'hA only for delayed-active pixels and 0 during porches/sync; first non-zero pin pixel 3 clocks after o_HSync rise.
- Mid-frame reset: assert i_Rst_L low while in H_SYNC at row 300 -> next edge o_VGA_HSync=1 and counters 0; after release, full normal frame follows.
- Border (VGA_SYNC_BORDER_EN): i_*_Video=0 -> pins 4'hF at columns 0/639 and rows 0/479, 0 elsewhere; same bench without the macro -> all 0.
